// File: rtl/spi_pkg.sv
// Shared types and frame constants for the single-bit SPI master.
// Every clock moves one bit, so frame indices are counted in clk cycles.
package spi_pkg;

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } cmd_kind_e;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      CMD,
      SHIFT,
      TAIL,
      RD_WAIT,
      RD_SHIFT,
      GAP
   } state_e;

   localparam int CMD_BITS  = 10;
   localparam int DATA_BITS = 8;
   localparam int TAIL_IDX  = 12;
   localparam int CNT_W     = 5;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   // Read-data frames carry no payload, so the data field goes out as zeros.
   function automatic logic [CMD_BITS-1:0] frame_word(input cmd_kind_e kind,
                                                      input logic [DATA_BITS-1:0] data);
      return {kind, (kind == RD_DATA) ? {DATA_BITS{1'b0}} : data};
   endfunction

endpackage

// File: rtl/spi_shift_unit.sv
// MOSI parallel-load shifter and MISO capture register for the SPI master.
// Only seven MISO bits are stored; the eighth is taken live on the final edge.
module spi_shift_unit
   import spi_pkg::*;
(
   input  logic                 clk,
   input  logic                 load_i,
   input  logic [CMD_BITS-1:0]  load_val_i,
   input  logic                 shift_i,
   input  logic                 cap_en_i,
   input  logic                 miso_i,
   output logic                 msb_o,
   output logic [DATA_BITS-1:0] byte_o
);

   logic [CMD_BITS-1:0]  sh_q;
   logic [DATA_BITS-2:0] cap_q;

   always_ff @(posedge clk) begin
      if (load_i) begin
         sh_q <= load_val_i;
      end else if (shift_i) begin
         sh_q <= {sh_q[CMD_BITS-2:0], 1'b0};
      end
      if (cap_en_i) begin
         cap_q <= {cap_q[DATA_BITS-3:0], miso_i};
      end
   end

   assign msb_o  = sh_q[CMD_BITS-1];
   assign byte_o = {cap_q, miso_i};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns host commands into SS_n/MOSI frames (one bit per clk)
// and captures the MISO read-back byte of read-data frames.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int IDLE_GAP   = 1,
   parameter int MISO_START = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_kind,
   input  logic [7:0] cmd_data,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       seq_err,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(TAIL_IDX - 1);
   localparam logic [CNT_W-1:0] RDW_LAST   = CNT_W'(MISO_START - 1);
   localparam logic [CNT_W-1:0] RDS_LAST   = CNT_W'(MISO_START + DATA_BITS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 2);
   // The IDLE clock with cmd_ready=1 is itself the last high clock of the gap.
   localparam state_e POST_ST  = (IDLE_GAP > 1) ? GAP : IDLE;
   localparam state_e FIRST_RD = (MISO_START > TAIL_IDX) ? RD_WAIT : RD_SHIFT;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   cmd_kind_e        kind_q, kind_d;
   logic             ss_n_q, ss_n_d;
   logic             mosi_q, mosi_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rd_valid_q, rd_valid_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             seq_err_q, seq_err_d;
   logic             addr_ok_q, addr_ok_d;

   logic                 accept;
   logic                 load, shift, cap_en;
   logic                 sh_msb;
   logic [DATA_BITS-1:0] rx_byte;
   logic [CMD_BITS-1:0]  load_val;

   assign accept   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
   assign load     = accept;
   assign load_val = frame_word(cmd_kind_e'(cmd_kind), cmd_data);

   spi_shift_unit u_shift (
      .clk        (clk),
      .load_i     (load),
      .load_val_i (load_val),
      .shift_i    (shift),
      .cap_en_i   (cap_en),
      .miso_i     (MISO),
      .msb_o      (sh_msb),
      .byte_o     (rx_byte)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_inc(cnt_q);
      kind_d    = kind_q;
      rd_valid_d = 1'b0;
      rd_data_d = rd_data_q;
      seq_err_d = seq_err_q;
      addr_ok_d = addr_ok_q;
      cap_en    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = SELECT;
               kind_d  = cmd_kind_e'(cmd_kind);
               if (cmd_kind_e'(cmd_kind) == RD_DATA && !addr_ok_q) begin
                  seq_err_d = 1'b1;
               end
            end
         end
         SELECT: state_d = CMD;
         CMD:    state_d = SHIFT;
         SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               state_d = (kind_q == RD_DATA) ? FIRST_RD : TAIL;
            end
         end
         TAIL: begin
            state_d = POST_ST;
            cnt_d   = '0;
            if (kind_q == RD_ADDR) begin
               addr_ok_d = 1'b1;
            end
         end
         RD_WAIT: begin
            if (cnt_q == RDW_LAST) begin
               state_d = RD_SHIFT;
            end
         end
         RD_SHIFT: begin
            cap_en = 1'b1;
            if (cnt_q == RDS_LAST) begin
               state_d    = POST_ST;
               cnt_d      = '0;
               rd_valid_d = 1'b1;
               rd_data_d  = rx_byte;
               addr_ok_d  = 1'b0;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pin values are decoded from the next state so every output is a flop.
      shift       = (state_d == SHIFT);
      mosi_d      = (state_d == CMD || state_d == SHIFT) ? sh_msb : 1'b0;
      ss_n_d      = (state_d == IDLE || state_d == GAP);
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         seq_err_q   <= 1'b0;
         addr_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         cmd_ready_q <= cmd_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         seq_err_q   <= seq_err_d;
         addr_ok_q   <= addr_ok_d;
      end
   end

   always_ff @(posedge clk) begin
      kind_q <= kind_d;
   end

   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;
   assign cmd_ready = cmd_ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + RAM model.
// A second instance with IDLE_GAP=3 covers back-to-back frame spacing.
module tb_spi_master_ctrl;

   localparam int MISO_START = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_kind = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       seq_err;
   logic       ss_n;
   logic       mosi;
   logic       miso = 1'b0;

   logic       c2_valid = 1'b0;
   logic       c2_ready;
   logic [1:0] c2_kind = 2'b00;
   logic [7:0] c2_data = 8'h00;
   logic       rdv2;
   logic [7:0] rdd2;
   logic       se2;
   logic       ss2;
   logic       mosi2;
   logic       miso2 = 1'b0;

   always #5 clk = ~clk;

   spi_master_ctrl #(.IDLE_GAP(1), .MISO_START(MISO_START)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_kind  (cmd_kind),
      .cmd_data  (cmd_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .seq_err   (seq_err),
      .SS_n      (ss_n),
      .MOSI      (mosi),
      .MISO      (miso)
   );

   spi_master_ctrl #(.IDLE_GAP(3), .MISO_START(MISO_START)) dut_g3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (c2_valid),
      .cmd_ready (c2_ready),
      .cmd_kind  (c2_kind),
      .cmd_data  (c2_data),
      .rd_valid  (rdv2),
      .rd_data   (rdd2),
      .seq_err   (se2),
      .SS_n      (ss2),
      .MOSI      (mosi2),
      .MISO      (miso2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Slave + RAM model: decodes complete frames (>=13 low clocks) and serves MISO.
   logic [7:0]  s_mem [256];
   logic [7:0]  s_wr_addr = 8'h00;
   logic [7:0]  s_rd_addr = 8'h00;
   logic [31:0] s_bits = '0;
   logic [9:0]  s_vec;
   int          s_k = 0;
   int          s_frames = 0;
   logic        s_prev = 1'b1;

   initial begin
      for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (!ss_n) begin
            if (s_prev) s_k = 0;
            else if (s_k < 31) s_k++;
            s_bits[s_k] = mosi;
            if (s_k >= MISO_START && s_k < MISO_START + 8 && s_bits[2] && s_bits[3])
               miso = s_mem[s_rd_addr][7 - (s_k - MISO_START)];
            else
               miso = 1'b0;
         end else begin
            miso = 1'b0;
            if (!s_prev && s_k >= 12) begin
               for (int i = 0; i < 10; i++) s_vec[9 - i] = s_bits[2 + i];
               s_frames++;
               case (s_vec[9:8])
                  2'b00:   s_wr_addr = s_vec[7:0];
                  2'b01:   s_mem[s_wr_addr] = s_vec[7:0];
                  2'b10:   s_rd_addr = s_vec[7:0];
                  default: ;
               endcase
            end
         end
         s_prev = ss_n;
      end
   end

   // Per-frame observations, k counted from the first SS_n-low clock.
   int          f_low;
   logic [12:0] f_bits;
   int          f_rdv_cnt;
   int          f_rdv_k;
   logic [7:0]  f_rdata;
   logic        f_seq0;

   task automatic run_frame(input logic [1:0] kind, input logic [7:0] data, input bit inject);
      int   guard;
      logic in_low;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         cyc();
         guard++;
      end
      check("ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_kind  = kind;
      cmd_data  = data;
      cyc();
      cmd_valid = 1'b0;
      cmd_kind  = 2'b00;
      cmd_data  = 8'h00;
      f_low = 0; f_bits = '0; f_rdv_cnt = 0; f_rdv_k = -1; f_rdata = 8'h00;
      f_seq0 = seq_err;
      in_low = 1'b1;
      for (int k = 0; k < 26; k++) begin
         if (in_low && !ss_n) f_low++;
         else in_low = 1'b0;
         if (k <= 12) f_bits = {f_bits[11:0], mosi};
         if (rd_valid) begin
            f_rdv_cnt++;
            f_rdv_k = k;
            f_rdata = rd_data;
         end
         if (inject && k == 4) begin
            cmd_valid = 1'b1;
            cmd_kind  = 2'b01;
            cmd_data  = 8'hFF;
         end else begin
            cmd_valid = 1'b0;
            cmd_kind  = 2'b00;
            cmd_data  = 8'h00;
         end
         cyc();
      end
   endtask

   int         guard;
   int         low;
   int         high;
   int         frames_before;
   logic [2:0] rp;
   logic       gm;

   initial begin
      // Reset state
      repeat (3) cyc();
      check("rst_ss_n", ss_n, 1);
      check("rst_mosi", mosi, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_seq_err", seq_err, 0);
      rst_n = 1'b1;
      cyc();
      check("rel_ready", cmd_ready, 1);

      // Reset at k=5 of a wr-addr frame
      cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_data = 8'h55;
      cyc();
      cmd_valid = 1'b0;
      check("mid_k0_ss_n", ss_n, 0);
      repeat (5) cyc();
      rst_n = 1'b0;
      cyc();
      check("mid_ss_n", ss_n, 1);
      check("mid_mosi", mosi, 0);
      check("mid_ready", cmd_ready, 0);
      check("mid_rd_valid", rd_valid, 0);
      check("mid_seq_err", seq_err, 0);
      rst_n = 1'b1;
      cyc();
      check("mid_rel_ready", cmd_ready, 1);
      cyc();
      check("mid_no_frame", s_frames, 0);

      // Write 0xA5 at 0x3C; MOSI k=0..12 = 0,[0,0,0,0,0,1,1,1,1,0,0],0
      run_frame(2'b00, 8'h3C, 1'b0);
      check("wa_low", f_low, 13);
      check("wa_bits", f_bits, 13'h0078);
      run_frame(2'b01, 8'hA5, 1'b0);
      check("wd_low", f_low, 13);
      check("wd_bits", f_bits, 13'h034A);
      check("ram_3c", s_mem[8'h3C], 8'hA5);

      // Read back 0x3C
      run_frame(2'b10, 8'h3C, 1'b0);
      check("ra_low", f_low, 13);
      check("ra_bits", f_bits, 13'h0C78);
      check("ra_rdv", f_rdv_cnt, 0);
      run_frame(2'b11, 8'h77, 1'b0);
      check("rd_low", f_low, 23);
      check("rd_bits", f_bits, 13'h0E00);
      check("rd_pulses", f_rdv_cnt, 1);
      check("rd_pulse_k", f_rdv_k, MISO_START + 8);
      check("rd_byte", f_rdata, 8'hA5);
      check("rd_seq_err", seq_err, 0);

      // Asymmetric byte 0x1E at 0x12 to pin down bit order
      run_frame(2'b00, 8'h12, 1'b0);
      check("wa2_bits", f_bits, 13'h0024);
      run_frame(2'b01, 8'h1E, 1'b0);
      check("wd2_bits", f_bits, 13'h023C);
      run_frame(2'b10, 8'h12, 1'b0);
      check("ra2_bits", f_bits, 13'h0C24);
      run_frame(2'b11, 8'h00, 1'b0);
      check("rd2_byte", f_rdata, 8'h1E);
      check("rd2_pulses", f_rdv_cnt, 1);
      check("rd2_seq_err", seq_err, 0);

      // Request during SHIFT is ignored; rd_data holds
      frames_before = s_frames;
      run_frame(2'b00, 8'h3C, 1'b1);
      check("ign_bits", f_bits, 13'h0078);
      check("ign_low", f_low, 13);
      check("ign_frames", s_frames, frames_before + 1);
      check("ign_ss_n", ss_n, 1);
      check("hold_rd_data", rd_data, 8'h1E);
      check("ign_ram", s_mem[8'hFF], 8'h00);

      // Sequence error: rd-data straight after reset
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      check("se_clear", seq_err, 0);
      run_frame(2'b11, 8'h00, 1'b0);
      check("se_k0", f_seq0, 1);
      check("se_low", f_low, 23);
      check("se_bits", f_bits, 13'h0E00);
      check("se_pulses", f_rdv_cnt, 1);
      run_frame(2'b00, 8'h10, 1'b0);
      check("se_wa_bits", f_bits, 13'h0020);
      run_frame(2'b10, 8'h10, 1'b0);
      check("se_sticky", seq_err, 1);

      // Back-to-back on the IDLE_GAP=3 instance
      c2_kind = 2'b00; c2_data = 8'h01; c2_valid = 1'b1;
      guard = 0;
      while (ss2 && guard < 20) begin
         cyc();
         guard++;
      end
      check("g_start", ss2, 0);
      low = 0;
      while (!ss2 && low < 40) begin
         low++;
         cyc();
      end
      check("g_low1", low, 13);
      high = 0; rp = 3'b000; gm = 1'b0;
      while (ss2 && high < 20) begin
         high++;
         rp = {rp[1:0], c2_ready};
         gm = gm | mosi2;
         cyc();
      end
      c2_valid = 1'b0;
      check("g_high", high, 3);
      check("g_ready_seq", rp, 3'b001);
      check("g_gap_mosi", gm, 0);
      low = 0;
      while (!ss2 && low < 40) begin
         low++;
         cyc();
      end
      check("g_low2", low, 13);
      check("g_side", {rdv2, se2, rdd2}, 10'h000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Initiator end of the team's single-bit SPI link. Converts a host command handshake into complete SS_n/MOSI frames for the SPI slave + RAM wrapper, and captures the MISO read-back byte.
- Sits between system logic and the slave wrapper. Shares clk with the slave. No SCLK is generated: one bit is transferred per clk.

Parameters:
- IDLE_GAP, 1: minimum clocks SS_n held high between frames (>=1).
- MISO_START, 15: frame clock index at which the first MISO bit is sampled (read-data frames).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  high when the block can accept a command
- cmd_kind  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
- cmd_data  in  8  address/data payload (ignored for rd-data)
- rd_valid  out  1  1-clock pulse: rd_data holds the returned byte
- rd_data  out  8  byte received on MISO, MSB first
- seq_err  out  1  sticky flag: rd-data issued without a prior rd-addr
- SS_n  out  1  slave select, active low
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

Behaviour:
- Reset (rst_n=0 at edge): SS_n=1, MOSI=0, cmd_ready=0, rd_valid=0, rd_data=0, seq_err=0, state IDLE.
- cmd_ready returns to 1 on the clock after reset releases.
- Reset mid-frame aborts immediately with the same values. No partial byte is reported.
- Handshake: command accepted on an edge where cmd_valid&&cmd_ready. cmd_kind/cmd_data are latched. cmd_ready drops the next clock and stays 0 until the post-frame gap completes.
- Frame clock index k=0 is the first clock with SS_n=0 (the clock after acceptance). All outputs are registered.
- k=0 SELECT: SS_n=0, MOSI=0.
- k=1 CMD: MOSI = cmd_kind[1]. This is the slave's write/read select bit.
- k=2..11 SHIFT: MOSI = {cmd_kind, cmd_data}[9..0], MSB first. For rd-data, cmd_data is driven as 0.
- Write/rd-addr frames (kind 00/01/10):
  - k=12 TAIL: SS_n=0, MOSI=0. This lets the slave raise rx_valid.
  - k=13: SS_n=1, enter GAP.
- Rd-data frame (kind 11):
  - k=12..MISO_START-1 RD_WAIT: SS_n=0, MOSI=0.
  - k=MISO_START..MISO_START+7 RD_SHIFT: sample MISO into a shift register, MSB first.
  - On the edge ending k=MISO_START+7: rd_data updated, rd_valid=1 for exactly one clock, SS_n=1 next clock.
- GAP: SS_n=1, MOSI=0 for IDLE_GAP clocks, then cmd_ready=1.
- The frame counter is 5 bits and saturates; no wrap is possible within a frame.
- rd_data holds its value until the next completed rd-data frame.
- Address tracking:
  - An internal flag is set by a completed rd-addr frame and cleared by a completed rd-data frame.
  - A rd-data command accepted with the flag clear sets seq_err (sticky until reset). The frame is still sent unchanged.
- cmd_valid during a frame is ignored. No queueing.
- A back-to-back command with cmd_valid held high is accepted on the first edge where cmd_ready=1.

Decomposition:
- Shared package spi_pkg:
  - enum cmd_kind_e (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA).
  - frame constants: CMD_BITS=10, DATA_BITS=8, TAIL_IDX=12.
  - state enum: IDLE, SELECT, CMD, SHIFT, TAIL, RD_WAIT, RD_SHIFT, GAP.
- One natural sub-module: spi_shift_unit. It is a parallel-load 10-bit MOSI shifter plus an 8-bit MISO capture register, with load/shift enables from the FSM.

Test Plan:
- Reset mid-frame: assert rst_n=0 at k=5 of a wr-addr frame -> next clock SS_n=1, MOSI=0, cmd_ready=0, rd_valid=0, seq_err=0. One clock after release, cmd_ready=1 and no RAM write is observed.
- Wr-addr then wr-data: send kind 00 data 0x3C, then kind 01 data 0xA5 -> MOSI at k=1..11 is 0,0,0,0,0,1,1,1,1,0,0 and SS_n low for exactly 13 clocks. Slave RAM mem[0x3C]==0xA5 afterwards.
- Full read-back: wr-addr 0x3C, wr-data 0xA5, rd-addr 0x3C, then rd-data -> rd_valid is a single pulse at k=MISO_START+8 with rd_data=0xA5. seq_err stays 0.
- Sequence error: after reset, issue rd-data directly -> seq_err=1 from the clock after acceptance. The frame is still emitted, and seq_err persists across the following legal frames.
- Back-to-back with IDLE_GAP=3: hold cmd_valid=1 for two commands -> SS_n high for exactly 3 clocks between frames. The second command is accepted the clock cmd_ready rises.
- Ignored request: pulse cmd_valid with kind 01 data 0xFF during the SHIFT of a frame -> no extra frame, and the in-flight frame's bits are unchanged.
